// File: rtl/gen192_sendtime.sv
// rtl/gen192_sendtime.sv - 192-bit counting-word generator with optional timestamp insertion.
// Optional error injection is compiled in with GEN192_ERRINJ_EN.
module gen192_sendtime #(
   parameter int BURST_LEN  = 0,
   parameter int GAP_CYCLES = 0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enable,
   input  logic         sendtime,
   input  logic [31:0]  time_now,
   input  logic         full,
`ifdef GEN192_ERRINJ_EN
   input  logic         inject,
`endif
   output logic [191:0] data,
   output logic         push,
   output logic         error,
   output logic         busy,
   output logic [31:0]  word_cnt
);

   typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

   localparam logic [31:0] BURST_L  = BURST_LEN;
   localparam logic [31:0] GAP_LAST = GAP_CYCLES - 1;

   state_t         state, state_nxt;
   logic [11:0]    base;
   logic [31:0]    burst_cnt;
   logic [31:0]    gap_cnt;
   logic           do_push;
   logic           burst_end;
   logic [191:0]   word;

   // Slot k carries base+k+1; the timestamp overlays the low 36 bits.
   always_comb begin
      word = '0;
      for (int k = 0; k < 16; k++) begin
         word[12*k +: 12] = base + 12'(k + 1);
      end
      if (sendtime) begin
         word[35:0] = {4'h0, time_now};
      end
   end

   always_comb begin
      state_nxt = state;
      do_push   = 1'b0;
      burst_end = (BURST_L != 32'd0) && ((burst_cnt + 32'd1) == BURST_L);
      case (state)
         IDLE: begin
            if (enable) state_nxt = SEND;
         end
         SEND: begin
            if (!enable) begin
               state_nxt = IDLE;
            end else if (!full) begin
               do_push = 1'b1;
               if (burst_end)            state_nxt = DONE;
               else if (GAP_CYCLES > 0)  state_nxt = GAP;
               else                      state_nxt = SEND;
            end
         end
         GAP: begin
            if (!enable)                 state_nxt = IDLE;
            else if (gap_cnt == GAP_LAST) state_nxt = SEND;
         end
         DONE: begin
            if (!enable) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

`ifdef GEN192_ERRINJ_EN
   logic inj_pend;
   logic inj_hit;

   // A request arriving in the same cycle as a push applies to that push.
   assign inj_hit = do_push & (inj_pend | inject);
`else
   logic inj_hit;

   assign inj_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         push      <= 1'b0;
         data      <= '0;
         word_cnt  <= '0;
         base      <= 12'hFFF;
         burst_cnt <= '0;
         gap_cnt   <= '0;
      end else begin
         state <= state_nxt;
         push  <= do_push;
         if (do_push) begin
            data      <= word ^ {11'd0, inj_hit, 180'd0};
            base      <= base + 12'd16;
            word_cnt  <= word_cnt + 32'd1;
            burst_cnt <= burst_cnt + 32'd1;
         end
         if (state_nxt == IDLE) begin
            burst_cnt <= '0;
         end
         if (state == GAP) gap_cnt <= gap_cnt + 32'd1;
         else              gap_cnt <= '0;
      end
   end

`ifdef GEN192_ERRINJ_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         error    <= 1'b0;
         inj_pend <= 1'b0;
      end else begin
         error <= inj_hit;
         if (do_push) inj_pend <= 1'b0;
         else         inj_pend <= inj_pend | inject;
      end
   end
`else
   assign error = 1'b0;
`endif

endmodule

// File: tb/tb_gen192_sendtime.sv
// tb/tb_gen192_sendtime.sv - randomized scoreboard bench for gen192_sendtime.
module tb_gen192_sendtime;

   logic         clk = 1'b0;
   logic         reset, enable, sendtime, full, enable_b;
   logic [31:0]  time_now;
   logic [191:0] data, data_b;
   logic         push, error, busy, push_b, error_b, busy_b;
   logic [31:0]  word_cnt, word_cnt_b;

   int total = 0;
   int bad   = 0;
   int n     = 0;

   always #5 clk = ~clk;

   gen192_sendtime dut (
      .clk(clk), .reset(reset), .enable(enable), .sendtime(sendtime),
      .time_now(time_now), .full(full), .data(data), .push(push),
      .error(error), .busy(busy), .word_cnt(word_cnt)
   );

   gen192_sendtime #(.BURST_LEN(4), .GAP_CYCLES(2)) dut_b (
      .clk(clk), .reset(reset), .enable(enable_b), .sendtime(1'b0),
      .time_now(32'h0), .full(1'b0), .data(data_b), .push(push_b),
      .error(error_b), .busy(busy_b), .word_cnt(word_cnt_b)
   );

   task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Word m of the stream holds the values 16m..16m+15 mod 4096 in its slots.
   function automatic logic [191:0] exp_word(input int m, input logic st, input logic [31:0] tn);
      logic [191:0] w;
      w = '0;
      for (int k = 0; k < 16; k++) w[12*k +: 12] = 12'((m * 16 + k) % 4096);
      if (st) w[35:0] = {4'h0, tn};
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One cycle of steady streaming: a push follows every cycle in which full was low.
   task automatic cyc();
      logic        pf, ps;
      logic [31:0] pt;
      pf = full;
      ps = sendtime;
      pt = time_now;
      tick();
      chk("push", push, !pf);
      chk("error", error, 1'b0);
      if (push) begin
         chk("data", data, exp_word(n, ps, pt));
         n++;
         chk("word_cnt", word_cnt, n);
         if (n == 257 && !ps) chk("wrap_slot0", data[11:0], 12'h000);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int t_push[$];
      int guard;

      reset = 1'b1; enable = 1'b0; sendtime = 1'b0; full = 1'b0;
      time_now = '0; enable_b = 1'b0;
      repeat (3) tick();
      chk("rst_push", push, 1'b0);
      chk("rst_data", data, '0);
      chk("rst_cnt", word_cnt, 32'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", error, 1'b0);
      chk("rst_busy_b", busy_b, 1'b0);

      reset = 1'b0; enable = 1'b1;
      tick();
      chk("start_push", push, 1'b0);
      chk("start_busy", busy, 1'b1);

      guard = 0;
      while (n < 262 && guard < 2000) begin
         guard++;
         if (guard <= 3) begin
            full = 1'b0; sendtime = 1'b0;
         end else if (guard == 5) begin
            full = 1'b0; sendtime = 1'b1; time_now = 32'h12345678;
         end else if (guard >= 20 && guard < 25) begin
            full = 1'b1; sendtime = 1'b0;
         end else begin
            full = ($urandom_range(3) == 0);
            sendtime = ($urandom_range(2) == 0);
            time_now = $urandom;
         end
         cyc();
      end
      chk("stream_len", (n >= 262), 1'b1);

      // Enable dropping stops the stream; re-enabling continues without rewind.
      full = 1'b0; sendtime = 1'b0; enable = 1'b0;
      tick();
      chk("drop_push", push, 1'b0);
      chk("drop_busy", busy, 1'b0);
      enable = 1'b1;
      tick();
      chk("reen_push", push, 1'b0);
      chk("reen_busy", busy, 1'b1);
      cyc();
      cyc();

      // Reset in the middle of streaming discards the scheduled push.
      reset = 1'b1;
      tick();
      chk("mid_rst_push", push, 1'b0);
      chk("mid_rst_cnt", word_cnt, 32'd0);
      chk("mid_rst_data", data, '0);
      reset = 1'b0;
      n = 0;
      tick();
      chk("post_rst_push", push, 1'b0);
      cyc();
      cyc();

      // Burst instance: four pushes, three cycles apart, then parked in DONE.
      enable_b = 1'b1;
      for (int t = 1; t <= 20; t++) begin
         tick();
         if (push_b) begin
            chk("b_data", data_b, exp_word(t_push.size(), 1'b0, 32'h0));
            t_push.push_back(t);
         end
      end
      chk("b_count", t_push.size(), 4);
      for (int i = 0; i < t_push.size(); i++) chk("b_time", t_push[i], 2 + 3 * i);
      chk("b_done_busy", busy_b, 1'b1);
      chk("b_done_cnt", word_cnt_b, 32'd4);
      enable_b = 1'b0;
      tick();
      chk("b_idle_busy", busy_b, 1'b0);
      enable_b = 1'b1;
      tick();
      chk("b_rerun_nopush", push_b, 1'b0);
      tick();
      chk("b_rerun_push", push_b, 1'b1);
      chk("b_rerun_data", data_b, exp_word(4, 1'b0, 32'h0));
      repeat (3) tick();
      chk("b_rerun_push2", push_b, 1'b1);
      chk("b_rerun_data2", data_b, exp_word(5, 1'b0, 32'h0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gen192_sendtime.md
GEN192_SENDTIME -- requirements
Module: gen192_sendtime

Interface
REQ-001 Parameter BURST_LEN, default 0, words per burst (0 = unlimited, run until enable falls).
REQ-002 Parameter GAP_CYCLES, default 0, idle cycles inserted after every pushed word.
REQ-003 Port clk  input  1  sole clock, all logic on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port enable  input  1  start/continue generation while high.
REQ-006 Port sendtime  input  1  insert timestamp in bits 31:0 of each word.
REQ-007 Port time_now  input  32  current time value for timestamp insertion.
REQ-008 Port full  input  1  downstream almost-full, at least one word of slack guaranteed.
REQ-009 Port data  output  192  generated word, sixteen 12-bit slots, slot k = bits 12k+11:12k.
REQ-010 Port push  output  1  data valid and written downstream this cycle.
REQ-011 Port error  output  1  word pushed this cycle is intentionally corrupted (macro build only, else tied 0).
REQ-012 Port busy  output  1  state is not IDLE.
REQ-013 Port word_cnt  output  32  count of words pushed since reset.

Function
REQ-014 Internal 12-bit base register; slot k of a word SHALL equal base+k+1 modulo 4096, with (base+1)[3:0] = 0.
REQ-015 Base SHALL reset to 12'hFFF and advance by 16 modulo 4096 on every push.
REQ-016 When sendtime is high at word build, bits 31:0 SHALL equal time_now sampled that cycle, bits 35:32 SHALL be 0; slots 3..15 unchanged.
REQ-017 data, push, error SHALL be registered; data SHALL hold its last value when push is low.
REQ-018 FSM states IDLE, SEND, GAP, DONE.
REQ-019 IDLE -> SEND when enable high.
REQ-020 In SEND, push SHALL assert on the next cycle iff full is low this cycle; full high SHALL stall in SEND with push low.
REQ-021 After a push: GAP if GAP_CYCLES > 0, else remain in SEND; GAP lasts exactly GAP_CYCLES cycles then returns to SEND.
REQ-022 When BURST_LEN > 0 and the burst count reaches BURST_LEN, transition to DONE instead of SEND/GAP.
REQ-023 DONE -> IDLE when enable is low; the burst counter SHALL clear on entering IDLE.
REQ-024 enable falling in SEND or GAP SHALL return to IDLE after any push already scheduled completes; base is not rewound.
REQ-025 Maximum rate one word per cycle with GAP_CYCLES = 0 and full low.
REQ-026 word_cnt SHALL increment by 1 per push and wrap from 32'hFFFFFFFF to 0.
REQ-027 Base wrap 12'hFEF -> 12'hFFF -> 12'h00F SHALL be seamless; slot values wrap through 0.

Reset
REQ-028 reset high SHALL force IDLE, push 0, error 0, busy 0, data 0, word_cnt 0, base 12'hFFF, burst and gap counters 0.
REQ-029 reset asserted mid-burst SHALL discard any scheduled push in the same cycle; first push after release carries slots 0..15 = 0..15.

Configuration
REQ-030 Macro GEN192_ERRINJ_EN compiled in: adds input inject (1 bit); a pending inject latched before a push SHALL invert bit 0 of slot 15 on the next pushed word and assert error with that push; base advances normally.
REQ-031 Without GEN192_ERRINJ_EN: no inject port, error constant 0, no corruption logic.

Verification
REQ-032 Reset, enable=1, sendtime=0, full=0, GAP=0 -> push every cycle from cycle 2; first word slots 0..15 = 0..15, second 16..31.
REQ-033 sendtime=1, time_now=32'h12345678 -> data[31:0]=32'h12345678, data[35:32]=0, slot 3 = base+4.
REQ-034 full high for 5 cycles mid-stream -> no push in 5 cycles; resumed word slot 0 continues exactly +16 from last pushed word.
REQ-035 BURST_LEN=4, GAP_CYCLES=2 -> 4 pushes spaced 3 cycles apart, then DONE, busy stays 1 until enable low.
REQ-036 Run 257 words -> word 256 slot 0 = 0 (wrap), word_cnt=257.
REQ-037 With GEN192_ERRINJ_EN, inject pulse -> exactly one word with slot 15 bit 0 flipped and error=1 on that push; next word correct.
